alu_mc: RTL

Parametrised multi-cycle ALU with a valid/ready handshake on both sides. It executes the team's 3-bit opcode set (add, sub, and, not, or, xor, mul, xnor) on WIDTH-bit operands:
- Single-cycle ops complete with 1-cycle latency.
- `mul` runs as an iterative shift-add over WIDTH cycles.

Results are registered with carry and zero flags and held until the consumer accepts them. The block sits between an operand-issuing controller and a result sink, and replaces the earlier fixed 8-bit combinational ALU.

---
 rtl/alu_mc.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes: logic/arith ops finish in one edge,
// mul runs as a WIDTH-step shift-add. Results are registered and held until accepted.
module alu_mc #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] y,
  output logic               carry,
  output logic               zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_XNOR = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] y_q;
  logic               out_valid_q;
  logic               carry_q;
  logic               zero_q;

  logic               accept_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     diff_s;
  logic [WIDTH-1:0]   logic_s;
  logic [2*WIDTH-1:0] res_d;
  logic               carry_d;
  logic [2*WIDTH-1:0] prod_d;

  assign in_ready = !rst && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
  assign accept_s = in_valid && in_ready;

  always_comb begin
    sum_s   = {1'b0, a} + {1'b0, b};
    // Top bit of the (WIDTH+1)-bit difference is the unsigned borrow.
    diff_s  = {1'b0, a} - {1'b0, b};
    logic_s = '0;
    case (op)
      OP_AND:  logic_s = a & b;
      OP_NOT:  logic_s = ~a;
      OP_OR:   logic_s = a | b;
      OP_XOR:  logic_s = a ^ b;
      OP_XNOR: logic_s = ~(a ^ b);
      default: logic_s = '0;
    endcase
    res_d   = '0;
    carry_d = 1'b0;
    case (op)
      OP_ADD: begin
        res_d   = {{(WIDTH-1){1'b0}}, sum_s};
        carry_d = sum_s[WIDTH];
      end
      OP_SUB: begin
        res_d   = {{WIDTH{1'b0}}, diff_s[WIDTH-1:0]};
        carry_d = diff_s[WIDTH];
      end
      default: begin
        res_d   = {{WIDTH{1'b0}}, logic_s};
        carry_d = 1'b0;
      end
    endcase
    prod_d = prod_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mcand_q     <= '0;
      prod_q      <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
    end else if (accept_s) begin
      if (op == OP_MUL) begin
        mcand_q     <= {{WIDTH{1'b0}}, a};
        mplier_q    <= b;
        prod_q      <= '0;
        cnt_q       <= CW'(WIDTH);
        out_valid_q <= 1'b0;
        state_q     <= S_MUL;
      end else begin
        y_q         <= res_d;
        carry_q     <= carry_d;
        zero_q      <= (res_d == '0);
        out_valid_q <= 1'b1;
        state_q     <= S_DONE;
      end
    end else begin
      case (state_q)
        S_MUL: begin
          prod_q   <= prod_d;
          mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
          cnt_q    <= cnt_q - CW'(1);
          // The last iteration publishes the product on the same edge.
          if (cnt_q == CW'(1)) begin
            y_q         <= prod_d;
            carry_q     <= 1'b0;
            zero_q      <= (prod_d == '0);
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            state_q <= S_MUL;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            state_q <= S_DONE;
          end
        end
        S_IDLE: state_q <= S_IDLE;
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign carry     = carry_q;
  assign zero      = zero_q;

endmodule
